// File: rtl/bcd_display_formatter.sv
// rtl/bcd_display_formatter.sv - binary to packed BCD converter with decimal-point mask
// Iterative double-dabble, one input bit per clock, outputs held between updates.
module bcd_display_formatter #(
   parameter int BIN_W = 27
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             dp_en,
   input  logic [2:0]       dp_sel,
   input  logic             start,
   output logic             ready,
   output logic [31:0]      data,
   output logic [7:0]       dps,
   output logic             valid,
   output logic             ovf
);

   localparam logic [31:0] BCD_MAX  = 32'd99_999_999;
   localparam logic [4:0]  CNT_INIT = 5'(BIN_W);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state;
   logic [BIN_W-1:0] shift_q;
   logic [31:0]      scratch_q;
   logic [31:0]      scratch_nxt;
   logic [30:0]      scratch_adj;
   logic [4:0]       cnt_q;
   logic             ovf_pending;
   logic [7:0]       dp_mask;
   logic [31:0]      bin_ext;
   logic             ovf_in;

   assign bin_ext = 32'(bin_in);
   assign ovf_in  = (BIN_W >= 27) && (bin_ext > BCD_MAX);

   // Add-3 on every nibble >= 5, then shift; bit 31 would only be lost on overflow.
   always_comb begin
      scratch_adj = '0;
      for (int i = 0; i < 7; i++) begin
         scratch_adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                               : scratch_q[4*i +: 4];
      end
      scratch_adj[30:28] = scratch_q[30:28] + ((scratch_q[31:28] >= 4'd5) ? 3'd3 : 3'd0);
      scratch_nxt        = {scratch_adj, shift_q[BIN_W-1]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         ready       <= 1'b1;
         valid       <= 1'b0;
         data        <= '0;
         dps         <= '0;
         ovf         <= 1'b0;
         shift_q     <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         ovf_pending <= 1'b0;
         dp_mask     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && ready) begin
                  shift_q     <= bin_in;
                  scratch_q   <= '0;
                  cnt_q       <= CNT_INIT;
                  ovf_pending <= ovf_in;
                  dp_mask     <= dp_en ? (8'b1 << dp_sel) : 8'h00;
                  ready       <= 1'b0;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               scratch_q <= scratch_nxt;
               shift_q   <= shift_q << 1;
               cnt_q     <= cnt_q - 5'd1;
               // Final shift result goes straight to the outputs; DONE holds the valid cycle.
               if (cnt_q == 5'd1) begin
                  state <= S_DONE;
                  valid <= 1'b1;
                  if (ovf_pending) begin
                     data <= 32'hEEEE_EEEE;
                     dps  <= 8'h00;
                     ovf  <= 1'b1;
                  end else begin
                     data <= scratch_nxt;
                     dps  <= dp_mask;
                     ovf  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               valid <= 1'b0;
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_display_formatter.md
# bcd_display_formatter

Binary-to-BCD front end for the MAX6951 display path. It converts an unsigned binary value into eight packed BCD digits and builds a decimal-point mask. The result drives the display driver's `data[31:0]` and `dps[7:0]` inputs directly. Conversion is an iterative shift-and-add-3 (double-dabble) engine, one bit per clock, with a start/ready/valid handshake. The outputs are held stable between updates, so the driver never samples an intermediate value.

## Interface
- `BIN_W`, default 27: width of the binary input. Legal range is 4..27.
- `clk`  in  1: system clock (66.6667 MHz), positive edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `bin_in`  in  BIN_W: unsigned value to convert. Sampled only when a start is accepted.
- `dp_en`  in  1: enables a decimal point. Sampled with `bin_in`.
- `dp_sel`  in  3: digit index (0 = least significant) whose decimal point is lit. Sampled with `bin_in`.
- `start`  in  1: conversion request. Accepted only on an edge where `ready` = 1.
- `ready`  out  1: high when idle and able to accept `start`.
- `data`  out  32: packed BCD result, digit k in `[4k+3:4k]`. Goes to the driver's `data`.
- `dps`  out  8: decimal-point mask. Goes to the driver's `dps`.
- `valid`  out  1: one-cycle pulse, coincident with `data`/`dps`/`ovf` being updated.
- `ovf`  out  1: high when the last accepted value exceeded 99,999,999. Holds until the next update.

## Operation
- **States:**
  - IDLE: `ready` = 1.
  - SHIFT: BIN_W cycles, `ready` = 0.
  - DONE: one cycle, `ready` = 0.
- **IDLE → SHIFT** on `start` && `ready`. On that edge:
  - load `bin_in` into the shift register;
  - clear the 32-bit BCD scratch register;
  - load the bit counter with BIN_W;
  - latch `ovf_pending` = (`bin_in` > 99,999,999);
  - latch `dp_mask` = `dp_en` ? (8'b1 << `dp_sel`) : 8'h00.
- **SHIFT, each cycle:**
  - every scratch nibble ≥ 5 gets +3 (all 8 nibbles corrected in parallel, combinationally);
  - then {scratch, shift} shifts left by 1;
  - the counter decrements.
  - When the counter reaches 0 after the final shift, go to DONE.
- **DONE:** register the outputs and pulse `valid`, then return to IDLE.
  - If `ovf_pending` = 0: `data` = scratch, `dps` = `dp_mask`, `ovf` = 0.
  - If `ovf_pending` = 1: `data` = 32'hEEEE_EEEE (displays "EEEEEEEE"), `dps` = 8'h00, `ovf` = 1.
- **Latency is fixed regardless of value or overflow.**
- **Width rules:**
  - The scratch register is 32 bits. Digits above the input's range stay 0.
  - For BIN_W < 27 overflow is impossible, and `ovf_pending` ties to 0.
- **`start` while `ready` = 0:** ignored, not queued. `bin_in`, `dp_en` and `dp_sel` changing mid-conversion have no effect.
- **Output stability:** `data`, `dps` and `ovf` change only on the DONE edge. They hold their value indefinitely otherwise.
- **Reset asserted at any time**, including mid-SHIFT:
  - state → IDLE, conversion abandoned, no `valid` produced;
  - reset values: `ready` = 1, `valid` = 0, `data` = 32'h0, `dps` = 8'h00, `ovf` = 0;
  - internal registers cleared.

## Timing
- Call the edge that accepts `start` edge T.
  - SHIFT occupies cycles T+1 … T+BIN_W.
  - DONE is cycle T+BIN_W+1. `data`/`dps`/`ovf` update, and `valid` rises, on the edge that begins it.
  - `valid` is high for exactly one cycle.
  - `ready` returns to 1 on edge T+BIN_W+2.
- A `start` held high is accepted again on the edge where `ready` = 1. This gives a back-to-back period of BIN_W+2 clocks (29 at default).
- The default latency of 28 clocks from start to valid is far below the driver's frame time. No handshake with the driver is needed, because the driver reads the held outputs whenever its own sequencer advances.
- The +3 correction plus shift fits one 66.67 MHz cycle (8 parallel 4-bit compare/add units).

## Test plan
- **Reset and zero:** release reset; check `ready` = 1, `data` = 0, `dps` = 0. Then `start` with `bin_in` = 0 → `valid` pulse exactly 28 clocks after accept, `data` = 32'h0000_0000, `ovf` = 0.
- **Typical value:** `bin_in` = 12,345,678, `dp_en` = 1, `dp_sel` = 2 → `data` = 32'h1234_5678, `dps` = 8'h04. `ready` returns 1 clock after `valid`.
- **Overflow boundary:** `bin_in` = 99,999,999 → `data` = 32'h9999_9999, `ovf` = 0. Then `bin_in` = 100,000,000 with `dp_en` = 1 → `data` = 32'hEEEE_EEEE, `dps` = 8'h00, `ovf` = 1, latency still 28.
- **Busy rejection and back-to-back:** accept `bin_in` = 42, then pulse `start` with `bin_in` = 7 at T+5 → exactly one `valid` with `data` = 32'h0000_0042. Holding `start` high gives the next accept at T+29.
- **Reset mid-operation:** assert `resetn` low at T+10 → `data`/`dps`/`ovf`/`valid` at reset values, no `valid` pulse. After release, a conversion of 905 gives `data` = 32'h0000_0905.
- **Parameter:** BIN_W = 8, `bin_in` = 255 → `data` = 32'h0000_0255, `valid` 9 clocks after accept, `ovf` = 0.
